int2float_pipe: RTL
===================

# int2float_pipe

Pipelined, parametrised integer-to-float converter: an IN_W-bit unsigned or two's-complement integer becomes a sign, a MAN_W-bit mantissa and an EXP_W-bit exponent such that |value| ≈ M·2^E. It is the sequential successor of the combinational 11-bit → 4+3 converter. It adds:
- width and signedness parameters,
- runtime-selectable rounding,
- saturation and status flags,
- a valid/ready streaming interface.

It sits between integer datapaths and compact-float storage or compare logic.

## Interface
- IN_W, 11: input integer width, ≥ MAN_W+1.
- MAN_W, 4: mantissa width, ≥ 2.
- EXP_W, 3: exponent width. Must satisfy 2^EXP_W−1 ≥ IN_W−MAN_W; elaboration error otherwise.
- SIGNED, 0: 1 means in_data is two's complement.

Ports:
- clk  in  1  clock.
- rst  in  1  reset. Synchronous and active-high, on the single clock clk.
- in_valid  in  1  input word valid.
- in_ready  out  1  converter can accept.
- in_data  in  IN_W  integer operand.
- in_rnd  in  1  rounding mode, travels with the data. 0 = truncate, 1 = round-to-nearest-even.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts.
- out_s  out  1  sign. Always 0 when SIGNED=0.
- out_m  out  MAN_W  mantissa.
- out_e  out  EXP_W  exponent.
- out_zero  out  1  input was 0.
- out_inexact  out  1  nonzero bits were discarded.
- out_ovf  out  1  result saturated.

## Operation
- Magnitude: a = |in_data|. For SIGNED=1 the most negative input gives a = 2^(IN_W−1), held in IN_W bits unsigned. out_s is the input sign bit.
- Leading-one position: p = position of the MSB set in a, 0-based. If a = 0, the result is out_m=0, out_e=0, out_zero=1, no other flags.
- Exponent: E = max(0, p−MAN_W+1).
- Truncated mantissa: M = a >> E. Remainder r = a mod 2^E; half = 2^(E−1).
- Inexact: out_inexact = (r ≠ 0).
- RNE rounding: increment M if r > half, or if r == half and M is odd.
- Mantissa carry: if the increment makes M = 2^MAN_W, set M = 2^(MAN_W−1) and E = E+1.
- Saturation: if E > 2^EXP_W−1 after the carry, output M = all ones and E = 2^EXP_W−1, with out_ovf=1 and out_inexact=1.
- Truncate mode: never sets out_ovf.
- Exact inputs: a < 2^MAN_W always gives E=0, M=a, out_inexact=0.

## Timing
- Pipeline has three register stages:
  - S1 captures the operand, rounding mode and magnitude.
  - S2 does leading-one detect and right shift, and captures M, E and the remainder bits.
  - S3 does rounding, carry handling, saturation and flags, and drives the outputs.
- Latency: 3 cycles from the input handshake (in_valid & in_ready) to out_valid, with no stall.
- Throughput: one word per cycle.
- Stage advance: stage k loads when it is empty or its content is leaving.
  - S3 leaves when out_valid & out_ready.
  - in_ready = !v1 | adv1. The ready chain is combinational and bubbles collapse.
- Handshake rules:
  - While out_valid=1 and out_ready=0, all out_* hold stable.
  - Ordering is strictly FIFO; no word is lost or duplicated.
- Upstream constraint: once in_valid is raised it must stay high until accepted.
- Reset, synchronously on rst:
  - v1..v3 clear to 0 and out_* clear to 0.
  - in_ready is 0 while rst is high, and 1 on the first cycle after rst falls.
  - Reset mid-stream discards all in-flight words.
- Simultaneous accept and emit: when in_valid and out_ready are both high with a full pipe, the pipe accepts one word and emits one word in the same cycle.

## Structure
- Package int2float_pkg holds:
  - constants RND_TRUNC=1'b0 and RND_RNE=1'b1,
  - function exp_w_min(IN_W, MAN_W) used for the parameter check,
  - the flag struct {zero, inexact, ovf}.
- Sub-module lead_one_det (parameter W) is a priority encoder returning p and a nonzero flag. It is used in S2.
- The rest is one module with one always block per stage plus the handshake logic.

## Test plan
Defaults are IN_W=11, MAN_W=4, EXP_W=3, SIGNED=0 unless stated.
- 0, RNE → out_m=0, out_e=0, zero=1, inexact=0, ovf=0. 13 → M=13, E=0, inexact=0.
- 100, truncate → M=12, E=3, inexact=1. 100, RNE (tie, even) → M=12, E=3. 108, RNE (tie, odd) → M=14, E=3.
- 31, RNE → mantissa carry → M=8, E=2, inexact=1. 31, truncate → M=15, E=1.
- 2047, RNE → M=15, E=7, ovf=1, inexact=1. 2047, truncate → M=15, E=7, ovf=0, inexact=1.
- SIGNED=1 cases:
  - −100, RNE → s=1, M=12, E=3.
  - −1024, i.e. a = 2^10 → s=1, M=8, E=7, inexact=0.
  - −1 → s=1, M=1, E=0.
- Streaming and reset:
  - Random 1000-word stream against a reference model, with random in_valid and out_ready: order and values match, and outputs hold stable while stalled.
  - out_ready held low for 5 cycles while offering 5 words: exactly 3 are accepted, then in_ready=0.
  - rst pulsed with the pipe full: out_valid=0 the next cycle and no stale word ever appears.

Source files
------------

// File: rtl/int2float_pkg.sv
// Purpose: shared constants, flag struct and parameter helper for int2float_pipe.
// Latency: n/a (package).
// Backpressure: n/a (package).
// Contents: rounding-mode encodings, result flag struct, minimum exponent width helper.
package int2float_pkg;

  localparam logic RND_TRUNC = 1'b0;
  localparam logic RND_RNE   = 1'b1;

  typedef struct packed {
    logic zero;
    logic inexact;
    logic ovf;
  } i2f_flags_t;

  // Smallest exponent width whose largest code (2^w-1) covers the widest
  // possible right shift, in_w - man_w.
  function automatic int exp_w_min(input int in_w, input int man_w);
    for (int w = 1; w < 31; w++) begin
      if (((1 << w) - 1) >= (in_w - man_w)) return w;
    end
    return 31;
  endfunction

endpackage

// File: rtl/int2float_pipe_if.sv
// Purpose: valid/ready stream bundle for int2float_pipe (operand in, float out).
// Latency: n/a (interface).
// Backpressure: in_ready/out_ready carry it; master = producer/consumer side, slave = converter.
// Signals: in_valid/in_ready/in_data/in_rnd, out_valid/out_ready/out_s/out_m/out_e/out_zero/out_inexact/out_ovf.
interface int2float_pipe_if #(
  parameter int IN_W  = 11,
  parameter int MAN_W = 4,
  parameter int EXP_W = 3
);
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_data;
  logic             in_rnd;
  logic             out_valid;
  logic             out_ready;
  logic             out_s;
  logic [MAN_W-1:0] out_m;
  logic [EXP_W-1:0] out_e;
  logic             out_zero;
  logic             out_inexact;
  logic             out_ovf;

  modport master (
    output in_valid, in_data, in_rnd, out_ready,
    input  in_ready, out_valid, out_s, out_m, out_e, out_zero, out_inexact, out_ovf
  );

  modport slave (
    input  in_valid, in_data, in_rnd, out_ready,
    output in_ready, out_valid, out_s, out_m, out_e, out_zero, out_inexact, out_ovf
  );
endinterface

// File: rtl/int2float_pipe_lead_one_det.sv
// Purpose: priority encoder giving the index of the most significant set bit.
// Latency: combinational.
// Backpressure: none.
// Ports: a (W-bit operand) in; p (index of MSB set, 0 when a==0) out; nz (a != 0) out.
module lead_one_det #(
  parameter int W  = 11,
  parameter int PW = (W > 1) ? $clog2(W) : 1
) (
  input  logic [W-1:0]  a,
  output logic [PW-1:0] p,
  output logic          nz
);

  // Ascending scan: the last set bit seen wins, i.e. the highest one.
  always_comb begin
    p  = '0;
    nz = 1'b0;
    for (int i = 0; i < W; i++) begin
      if (a[i]) begin
        p  = PW'(i);
        nz = 1'b1;
      end
    end
  end

endmodule

// File: rtl/int2float_pipe.sv
// Purpose: integer to sign/mantissa/exponent converter with truncate or RNE rounding.
// Latency: 3 cycles from input handshake to out_valid, one word per cycle.
// Backpressure: combinational ready chain; a stage loads when empty or draining, so bubbles collapse.
// Ports: clk, rst (sync, active-high); io (slave) carries the input operand stream and result stream.
module int2float_pipe
  import int2float_pkg::*;
#(
  parameter int IN_W   = 11,
  parameter int MAN_W  = 4,
  parameter int EXP_W  = 3,
  parameter bit SIGNED = 1'b0
) (
  input logic              clk,
  input logic              rst,
  int2float_pipe_if.slave  io
);

  localparam int               PW     = $clog2(IN_W);
  localparam logic [PW-1:0]    TOP_M  = PW'(MAN_W - 1);
  localparam logic [EXP_W-1:0] E_MAX  = '1;

  if (IN_W < MAN_W + 1) begin : g_bad_in_w
    $error("int2float_pipe: IN_W must be at least MAN_W+1");
  end
  if (MAN_W < 2) begin : g_bad_man_w
    $error("int2float_pipe: MAN_W must be at least 2");
  end
  if (EXP_W < exp_w_min(IN_W, MAN_W)) begin : g_bad_exp_w
    $error("int2float_pipe: EXP_W too small for IN_W-MAN_W shift range");
  end

  // ---------------- handshake ----------------
  logic v1, v2, v3;
  logic ld1, ld2, ld3;
  logic in_fire;

  assign ld3         = !v3 || io.out_ready;
  assign ld2         = !v2 || ld3;
  assign ld1         = !v1 || ld2;
  assign io.in_ready = ld1 && !rst;
  assign in_fire     = io.in_valid && io.in_ready;

  // ---------------- S1: sign and magnitude ----------------
  logic            s_in;
  logic [IN_W-1:0] a_in;
  logic            s1_s, s1_rnd;
  logic [IN_W-1:0] s1_a;

  // The most negative input negates to itself, which read unsigned is 2^(IN_W-1).
  always_comb begin
    s_in = (SIGNED != 1'b0) ? io.in_data[IN_W-1] : 1'b0;
    a_in = s_in ? (~io.in_data + IN_W'(1)) : io.in_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1     <= 1'b0;
      s1_s   <= 1'b0;
      s1_rnd <= 1'b0;
      s1_a   <= '0;
    end else if (ld1) begin
      v1 <= in_fire;
      if (in_fire) begin
        s1_s   <= s_in;
        s1_rnd <= io.in_rnd;
        s1_a   <= a_in;
      end
    end
  end

  // ---------------- S2: normalise ----------------
  logic [PW-1:0]    lod_p;
  logic             lod_nz;
  logic [PW-1:0]    sh;
  logic [IN_W-1:0]  keep_mask;
  logic [MAN_W-1:0] m_nx;
  logic             rbit_nx, sticky_nx;

  logic             s2_s, s2_rnd, s2_zero, s2_rbit, s2_sticky;
  logic [MAN_W-1:0] s2_m;
  logic [EXP_W-1:0] s2_e;

  lead_one_det #(.W(IN_W), .PW(PW)) u_lod (
    .a  (s1_a),
    .p  (lod_p),
    .nz (lod_nz)
  );

  // keep_mask covers the discarded bits; its top bit is the half-ulp bit,
  // everything below it folds into sticky.
  always_comb begin
    sh        = (lod_p > TOP_M) ? (lod_p - TOP_M) : '0;
    keep_mask = (IN_W'(1) << sh) - IN_W'(1);
    m_nx      = MAN_W'(s1_a >> sh);
    rbit_nx   = |(s1_a & keep_mask & ~(keep_mask >> 1));
    sticky_nx = |(s1_a & (keep_mask >> 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v2        <= 1'b0;
      s2_s      <= 1'b0;
      s2_rnd    <= 1'b0;
      s2_zero   <= 1'b0;
      s2_m      <= '0;
      s2_e      <= '0;
      s2_rbit   <= 1'b0;
      s2_sticky <= 1'b0;
    end else if (ld2) begin
      v2 <= v1;
      if (v1) begin
        s2_s      <= s1_s;
        s2_rnd    <= s1_rnd;
        s2_zero   <= !lod_nz;
        s2_m      <= m_nx;
        s2_e      <= EXP_W'(sh);
        s2_rbit   <= rbit_nx;
        s2_sticky <= sticky_nx;
      end
    end
  end

  // ---------------- S3: round, carry, saturate ----------------
  logic             inc, carry, sat;
  logic [MAN_W:0]   sum_m;
  logic [EXP_W:0]   e_rnd;
  logic [MAN_W-1:0] m_fin;
  logic [EXP_W-1:0] e_fin;
  i2f_flags_t       flags_fin;

  logic             s3_s;
  logic [MAN_W-1:0] s3_m;
  logic [EXP_W-1:0] s3_e;
  i2f_flags_t       s3_flags;

  // Truncation never carries, and without a carry E stays within range,
  // so saturation is reachable only through RNE.
  always_comb begin
    inc   = (s2_rnd == RND_RNE) && s2_rbit && (s2_sticky || s2_m[0]);
    sum_m = {1'b0, s2_m} + (MAN_W+1)'(inc);
    carry = sum_m[MAN_W];
    e_rnd = {1'b0, s2_e} + (EXP_W+1)'(carry);
    sat   = e_rnd > {1'b0, E_MAX};
    if (sat)        m_fin = '1;
    else if (carry) m_fin = {1'b1, {(MAN_W-1){1'b0}}};
    else            m_fin = sum_m[MAN_W-1:0];
    e_fin             = sat ? E_MAX : e_rnd[EXP_W-1:0];
    flags_fin.zero    = s2_zero;
    flags_fin.inexact = s2_rbit || s2_sticky || sat;
    flags_fin.ovf     = sat;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v3       <= 1'b0;
      s3_s     <= 1'b0;
      s3_m     <= '0;
      s3_e     <= '0;
      s3_flags <= '0;
    end else if (ld3) begin
      v3 <= v2;
      if (v2) begin
        s3_s     <= s2_s;
        s3_m     <= m_fin;
        s3_e     <= e_fin;
        s3_flags <= flags_fin;
      end
    end
  end

  assign io.out_valid   = v3;
  assign io.out_s       = s3_s;
  assign io.out_m       = s3_m;
  assign io.out_e       = s3_e;
  assign io.out_zero    = s3_flags.zero;
  assign io.out_inexact = s3_flags.inexact;
  assign io.out_ovf     = s3_flags.ovf;

endmodule
